fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port if_packet_in  input  IF_ID_PACKET  fetched instruction from ifetch; enqueue request when if_packet_in.valid=1.
REQ-005 SHALL have port flush  input  1  squash from EX certain branch or ROB redirect; discards all entries.
REQ-006 SHALL have port id_ready  input  1  decode/dispatch accepts head this cycle.
REQ-007 SHALL have port id_packet_out  output  IF_ID_PACKET  head entry toward decode.
REQ-008 SHALL have port id_valid  output  1  id_packet_out holds a real instruction.
REQ-009 SHALL have port fq_full  output  1  no free entry; ifetch stalls PC.
REQ-010 SHALL have port fq_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-011 SHALL enqueue if_packet_in at tail when if_packet_in.valid=1, fq_full=0, flush=0; entry visible at head no earlier than next cycle.
REQ-012 SHALL ignore if_packet_in when valid=0 or fq_full=1, even if a dequeue occurs that cycle.
REQ-013 SHALL dequeue head when id_valid=1 and id_ready=1 and flush=0.
REQ-014 SHALL on simultaneous enqueue and dequeue (not full, not empty) keep fq_count unchanged and advance both pointers.
REQ-015 SHALL wrap head/tail pointers modulo DEPTH; order is strict FIFO across wrap.
REQ-016 SHALL assert fq_full exactly when fq_count==DEPTH; id_valid exactly when fq_count!=0 (except REQ-022).
REQ-017 SHALL drive id_packet_out all-zero (valid=0) when empty.
REQ-018 SHALL force id_packet_out.valid equal to id_valid.
REQ-019 SHALL on flush=1 zero count and pointers at next edge; flush overrides enqueue/dequeue same cycle; id_valid forced 0 during flush cycle.
REQ-020 SHALL preserve PC, NPC, inst fields bit-exact through the queue.

Reset
REQ-021 SHALL on reset=0 immediately clear pointers, fq_count=0, fq_full=0, id_valid=0, id_packet_out=0, regardless of clock; entry payloads need not clear; in-flight enqueue in that cycle is lost.

Configuration
REQ-022 SHALL with FQ_BYPASS_EN defined, when empty, flush=0, if_packet_in.valid=1, pass if_packet_in combinationally to id_packet_out with id_valid=1; if id_ready=1 nothing is stored, else it is enqueued normally.
REQ-023 SHALL without FQ_BYPASS_EN have minimum enqueue-to-output latency of one cycle and no combinational path from if_packet_in to id_*.

Structure
REQ-024 SHALL take IF_ID_PACKET from sys_defs.svh; FQ_DEPTH default constant belongs in shared package/header.
REQ-025 SHALL place storage in sub-module fq_mem (DEPTH x IF_ID_PACKET, one write port, one async read port); pointer/count control stays in fetch_queue.

Verification
REQ-026 SHALL cover: reset, enqueue PC 0x0,0x4,0x8 one per cycle, id_ready=1 -> outputs 0x0,0x4,0x8 in order, count ends 0.
REQ-027 SHALL cover: id_ready=0, enqueue 9 packets into DEPTH=8 -> fq_full=1 after 8th, 9th dropped, count=8.
REQ-028 SHALL cover: full queue, enqueue+dequeue same cycle -> enqueue rejected, count=7; subsequent cycle enqueue accepted, count=8.
REQ-029 SHALL cover: 20 packets through DEPTH=8 with random id_ready -> order and fields preserved across pointer wrap.
REQ-030 SHALL cover: count=5, flush=1 with valid if_packet_in and id_ready=1 -> next cycle count=0, id_valid=0, nothing dequeued.
REQ-031 SHALL cover: reset asserted mid-cycle between edges with count=3 -> id_valid and fq_count drop to 0 before next edge; with FQ_BYPASS_EN, empty queue, PC 0x1111_1111 in, id_ready=1 -> id_packet_out.PC=0x1111_1111 same cycle, count stays 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch queue between instruction fetch and decode.
//   FQ_DEPTH      : default number of queue entries
//   IF_ID_PACKET  : fetched-instruction packet passed from IF to ID
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 8;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] PC;
  } IF_ID_PACKET;

endpackage

// File: rtl/fq_mem.sv
// -----------------------------------------------------------------------------
// fq_mem
// Entry storage for fetch_queue: DEPTH x IF_ID_PACKET, one synchronous write
// port and one asynchronous (combinational) read port.
// Ports:
//   clock    : system clock, writes on rising edge
//   we_i     : write enable
//   waddr_i  : write address (queue tail)
//   wdata_i  : packet to store
//   raddr_i  : read address (queue head)
//   rdata_o  : packet at raddr_i, combinational
// -----------------------------------------------------------------------------
module fq_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  IF_ID_PACKET              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output IF_ID_PACKET              rdata_o
);

  IF_ID_PACKET mem_q [DEPTH];

  // NOTE: payload storage has no reset; the control logic never exposes an
  // entry that was not written since the last reset or flush.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular FIFO decoupling instruction fetch from decode/dispatch.
// Optional feature macro: FQ_BYPASS_EN -- when defined, a valid incoming packet
// on an empty queue is presented to decode in the same cycle; if decode takes
// it, nothing is stored. Without it, there is no combinational path from
// if_packet_in to the id_* outputs.
// Ports:
//   clock         : system clock, rising edge
//   reset         : asynchronous active-low reset
//   if_packet_in  : packet from ifetch, enqueue request when .valid=1
//   flush         : squash, discards all entries at next edge
//   id_ready      : decode accepts the head this cycle
//   id_packet_out : head packet toward decode (all-zero when nothing valid)
//   id_valid      : id_packet_out carries a real instruction
//   fq_full       : no free entry; ifetch must stall
//   fq_count      : number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  IF_ID_PACKET            if_packet_in,
  input  logic                   flush,
  input  logic                   id_ready,
  output IF_ID_PACKET            id_packet_out,
  output logic                   id_valid,
  output logic                   fq_full,
  output logic [$clog2(DEPTH):0] fq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        empty;
  logic        enq;
  logic        deq;
  IF_ID_PACKET rd_data;

  assign empty    = (count_q == '0);
  assign fq_full  = (count_q == FULL_CNT);
  assign fq_count = count_q;

  // Handshake and head presentation. Full is judged on the registered count,
  // so a dequeue in the same cycle never opens room for an enqueue.
  // NOTE: every signal driven here gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    enq           = if_packet_in.valid && !fq_full && !flush;
    deq           = !empty && id_ready && !flush;
    id_valid      = !empty && !flush;
    id_packet_out = id_valid ? rd_data : '0;
    id_packet_out.valid = id_valid;
`ifdef FQ_BYPASS_EN
    // Empty-queue bypass; held off while reset is asserted so outputs stay
    // clear during reset.
    if (empty && !flush && if_packet_in.valid && reset) begin
      id_valid            = 1'b1;
      id_packet_out       = if_packet_in;
      id_packet_out.valid = 1'b1;
      if (id_ready) begin
        enq = 1'b0;
      end
    end
`endif
  end

  // Pointer/count next state. Pointers are PTR_W bits wide, so the +1 wraps
  // modulo DEPTH (DEPTH is a power of two).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock   (clock),
    .we_i    (enq),
    .waddr_i (tail_q),
    .wdata_i (if_packet_in),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

endmodule
